// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and helpers for the MMIO parallel port.
//   DEFAULT_BASE_ADDR : default first address of the I/O window
//   OFS_OUT           : offset of output register 0 within the window
//   OFS_IN()          : offset of input channel 0 (follows the outputs)
//   OFS_STATUS()      : offset of the change-status register (last slot)
//   win_size()        : number of addresses decoded by the window
package mmio_pkg;

  localparam logic [7:0] DEFAULT_BASE_ADDR = 8'hF8;
  localparam int         OFS_OUT           = 0;

  function automatic int OFS_IN(input int n_out);
    return OFS_OUT + n_out;
  endfunction

  function automatic int OFS_STATUS(input int n_out, input int n_in);
    return OFS_OUT + n_out + n_in;
  endfunction

  function automatic int win_size(input int n_out, input int n_in);
    return n_out + n_in + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: W-bit two-flop synchroniser for asynchronous board inputs.
//   clk  : sampling clock
//   rst  : asynchronous active-low reset, clears both stages
//   d_i  : asynchronous input
//   q_o  : synchronised output (two clk edges after d_i)
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/mmio_parallel_port.sv
// mmio_parallel_port: memory-mapped bank of N_OUT output registers, N_IN
// synchronised input channels and a read-to-clear change-status register.
//   clk, rst     : CPU clock, asynchronous active-low reset
//   addr         : data address (ALU result)
//   wdata, we    : store data and strobe
//   re           : load strobe (clears STATUS when it is the address)
//   mem_rdata    : RAM read data, passed through outside the window
//   rdata, hit   : combinational load data and window decode
//   din          : asynchronous inputs, channel k at din[k*DATA_W +: DATA_W]
//   dout         : registered outputs, out_stb: one-cycle write pulse each
// Build option MMIO_CHANGE_FLAGS_EN: when defined, each input keeps a history
// register and a sticky change flag readable at STATUS. When undefined STATUS
// reads 0 and reading it has no side effect; the window size is unchanged.
module mmio_parallel_port
  import mmio_pkg::*;
#(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter int                N_OUT     = 2,
  parameter int                N_IN      = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEFAULT_BASE_ADDR)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        addr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     we,
  input  logic                     re,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     hit,
  input  logic [N_IN*DATA_W-1:0]   din,
  output logic [N_OUT*DATA_W-1:0]  dout,
  output logic [N_OUT-1:0]         out_stb
);

  localparam logic [ADDR_W-1:0] LAST_OFS = ADDR_W'(win_size(N_OUT, N_IN) - 1);
  localparam logic [ADDR_W-1:0] STAT_OFS = ADDR_W'(OFS_STATUS(N_OUT, N_IN));

  // Offset is only meaningful under hit, where addr >= BASE_ADDR, so the
  // subtraction never wraps.
  logic [ADDR_W-1:0] ofs;
  assign ofs = addr - BASE_ADDR;
  assign hit = (addr >= BASE_ADDR) && (ofs <= LAST_OFS);

  // ---------------- output registers ----------------
  logic [N_OUT-1:0][DATA_W-1:0] dout_q, dout_d;
  logic [N_OUT-1:0]             stb_q, stb_d;

  always_comb begin
    dout_d = dout_q;
    stb_d  = '0;
    if (we && hit) begin
      for (int k = 0; k < N_OUT; k++) begin
        if (ofs == ADDR_W'(OFS_OUT + k)) begin
          dout_d[k] = wdata;
          stb_d[k]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      stb_q  <= '0;
    end else begin
      dout_q <= dout_d;
      stb_q  <= stb_d;
    end
  end

  assign dout    = dout_q;
  assign out_stb = stb_q;

  // ---------------- input synchronisers ----------------
  logic [N_IN-1:0][DATA_W-1:0] s2;

  for (genvar j = 0; j < N_IN; j++) begin : g_in
    sync_2ff #(.W(DATA_W)) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (din[j*DATA_W +: DATA_W]),
      .q_o (s2[j])
    );
  end

  // ---------------- change flags / STATUS ----------------
  logic [DATA_W-1:0] status;

`ifdef MMIO_CHANGE_FLAGS_EN
  logic [N_IN-1:0][DATA_W-1:0] prev_q;
  logic [N_IN-1:0]             flag_q, flag_d, chg;
  logic                        clr;

  assign clr = re && hit && (ofs == STAT_OFS);

  always_comb begin
    for (int j = 0; j < N_IN; j++) chg[j] = (s2[j] != prev_q[j]);
  end

  // A change detected on the clearing edge survives the clear.
  assign flag_d = chg | (flag_q & {N_IN{~clr}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= '0;
      flag_q <= '0;
    end else begin
      prev_q <= s2;
      flag_q <= flag_d;
    end
  end

  assign status = DATA_W'(flag_q);
`else
  logic unused_re;
  assign unused_re = re;
  assign status    = '0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    rdata = mem_rdata;
    if (hit) begin
      rdata = status;
      for (int k = 0; k < N_OUT; k++)
        if (ofs == ADDR_W'(OFS_OUT + k)) rdata = dout_q[k];
      for (int j = 0; j < N_IN; j++)
        if (ofs == ADDR_W'(OFS_IN(N_OUT) + j)) rdata = s2[j];
      if (ofs == STAT_OFS) rdata = status;
    end
  end

endmodule

// File: doc/mmio_parallel_port.md
# mmio_parallel_port

Parametrised memory-mapped parallel I/O bank for the single-cycle RISC-V datapath. It generalises the single-address in/out port to `N_OUT` output registers, `N_IN` synchronised input channels and a sticky change-status register, all in one address window. It sits beside the data RAM: it decodes the ALU address, supplies write-back read data, and drives board I/O such as LEDs, LCD fields and switches.

## Interface
- `DATA_W`, default 8: width of each data channel and of the CPU data bus.
- `ADDR_W`, default 8: width of the data address.
- `N_OUT`, default 2: number of output registers, 1..8.
- `N_IN`, default 2: number of input channels, 1..`DATA_W`.
- `BASE_ADDR`, default 8'hF8: first address of the window. The window must fit below 2^`ADDR_W`.

Ports:
- `clk` in, 1 bit: CPU clock. Already decided.
- `rst` in, 1 bit: asynchronous, active-low reset. Already decided.
- `addr` in, `ADDR_W` bits: ALU result used as the data address.
- `wdata` in, `DATA_W` bits: store data, taken from rs2.
- `we` in, 1 bit: store strobe (MemWrite).
- `re` in, 1 bit: load strobe; high when the instruction is a load.
- `mem_rdata` in, `DATA_W` bits: RAM read data.
- `rdata` out, `DATA_W` bits: load data to the result mux.
- `hit` out, 1 bit: `addr` is inside the window. The top level gates the RAM write with `~hit`.
- `din` in, `N_IN*DATA_W` bits: asynchronous external inputs. Channel k is `din[k*DATA_W +: DATA_W]`.
- `dout` out, `N_OUT*DATA_W` bits: registered outputs.
- `out_stb` out, `N_OUT` bits: one-cycle pulse per output channel when that channel is written.

## Operation
- Address map:
  - `BASE_ADDR+k`, for k < `N_OUT`: output register k, read/write.
  - `BASE_ADDR+N_OUT+j`, for j < `N_IN`: synchronised input j, read-only.
  - `BASE_ADDR+N_OUT+N_IN`: STATUS, read-to-clear. Bit j is the change flag of input j; upper bits read 0.
- `hit` is combinational: `BASE_ADDR <= addr <= BASE_ADDR+N_OUT+N_IN`.
- `rdata` is combinational. On `hit` it returns the addressed register; otherwise it passes `mem_rdata` through.
- Write: on a rising edge with `we && hit` and `addr` in the output range, `dout[k] <= wdata` and `out_stb[k] <= 1`. In every other cycle `out_stb` is 0.
- Writes to input or STATUS addresses are ignored. No RAM write takes place because `hit` gates it.
- Input path per channel: two-flop synchroniser `s1 <= din`, `s2 <= s1`; history register `prev <= s2`. Reads of input j return `s2`.
- Change flag j: set on the edge where `s2 != prev`. Cleared on the edge where `re && addr == STATUS`.
- Flag set and clear in the same edge: set wins, so no change is lost.
- Arithmetic: offsets are computed as `addr - BASE_ADDR` in `ADDR_W` bits, evaluated only when `hit`, so wrap-around is impossible.
- Reset values:
  - `dout` = 0, `out_stb` = 0.
  - `s1`, `s2`, `prev` = 0; all flags = 0.
  - `rdata` follows `mem_rdata` or 0-valued registers.
- Reset mid-operation clears everything immediately and asynchronously. A store in flight is lost.

## Timing
- Write latency: `dout` updates at the rising edge that ends the store cycle. `out_stb` is high for exactly the following cycle.
- Read latency: 0 cycles; `rdata` is combinational on `addr`.
- `din` to readable value: 2 rising edges.
- `din` change to flag visible: 3 rising edges. The flag is set on the edge after `s2` changes.
- STATUS read-to-clear: the value read in the load cycle is pre-clear. The flag reads 0 from the next cycle unless set again in the same edge.
- Back-to-back stores to the same channel: each store updates `dout`, and `out_stb` stays high continuously.

## Configuration
- `MMIO_CHANGE_FLAGS_EN` defined: `prev`, the change flags and the STATUS register are built as described.
- Not defined: the `prev` register and flags are removed. STATUS reads 0, and reads of it have no side effect. `hit` still covers the STATUS address, so the window size is unchanged.

## Structure
- Package `mmio_pkg`:
  - default `BASE_ADDR`;
  - offset constants `OFS_OUT`, `OFS_IN(N_OUT)`, `OFS_STATUS(N_OUT,N_IN)`;
  - a function returning window size `N_OUT+N_IN+1`.
- One sub-module, `sync_2ff`: a `DATA_W`-bit two-flop synchroniser with asynchronous active-low reset, instantiated `N_IN` times.

## Test plan
- Reset, then store 8'hA5 to 8'hF8 -> `dout[0]`=A5 after one edge, `out_stb`=01 for one cycle, RAM write gated (`hit`=1); load from 8'hF8 returns A5.
- Drive `din[1]`=8'h3C asynchronously -> load from 8'hFB returns 3C after 2 edges, STATUS (8'hFC) bit1=1 after 3 edges.
- Load STATUS with bit1 set -> `rdata`=8'h02 in that cycle, 8'h00 on the next load.
- Toggle `din[0]` so its flag sets on the same edge as a STATUS read-clear -> bit0 remains 1.
- Load/store to 8'h10 -> `hit`=0, `rdata`=`mem_rdata`, `dout` unchanged; store to 8'hFA (input) -> ignored.
- Assert `rst` low mid-sequence with `dout` nonzero and flags set -> all outputs and flags 0 immediately; with `MMIO_CHANGE_FLAGS_EN` undefined, STATUS always reads 0.
